// File: rtl/pwm_compare.sv
// PWM comparator: compares CNTR against a double-buffered duty and drives a registered PWM output.
// Defining PWM_INVERT_EN makes the waveform active-low (PWM_OUT resets to 1).
module pwm_compare #(
  parameter int WIDTH    = 4,
  parameter int RST_DUTY = 8
) (
  input  logic             CLoK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] CNTR,
  input  logic [WIDTH:0]   DUTY_IN,
  input  logic             DUTY_LD,
  output logic             PWM_OUT,
  output logic             UPD_PEND,
  output logic             UPD_DONE,
  output logic             PERIOD_END
);

  localparam logic [WIDTH:0] DUTY_MAX  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] RST_DUTY_C =
      (RST_DUTY > (2 ** WIDTH)) ? DUTY_MAX : (WIDTH+1)'(RST_DUTY);

`ifdef PWM_INVERT_EN
  localparam logic PWM_POL = 1'b1;
`else
  localparam logic PWM_POL = 1'b0;
`endif

  typedef enum logic {IDLE, PENDING} state_t;

  state_t         state_q;
  logic [WIDTH:0] duty_act_q;
  logic [WIDTH:0] duty_pend_q;
  logic           pwm_q;
  logic           upd_done_q;
  logic           period_end_q;

  logic           wrap;
  logic [WIDTH:0] duty_in_clamped;
  logic           pwm_d;

  assign wrap            = (CNTR == {WIDTH{1'b1}});
  assign duty_in_clamped = (DUTY_IN > DUTY_MAX) ? DUTY_MAX : DUTY_IN;
  // The compare always sees the duty that was active before this edge.
  assign pwm_d           = ({1'b0, CNTR} < duty_act_q) ^ PWM_POL;

  always_ff @(posedge CLoK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      duty_act_q   <= RST_DUTY_C;
      duty_pend_q  <= RST_DUTY_C;
      pwm_q        <= PWM_POL;
      upd_done_q   <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      pwm_q        <= pwm_d;
      period_end_q <= wrap;
      upd_done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A load on a wrap edge is only captured; it waits for the next wrap.
          if (DUTY_LD) begin
            duty_pend_q <= duty_in_clamped;
            state_q     <= PENDING;
          end
        end
        PENDING: begin
          if (wrap) begin
            duty_act_q <= duty_pend_q;
            upd_done_q <= 1'b1;
            if (DUTY_LD) begin
              duty_pend_q <= duty_in_clamped;
            end else begin
              state_q <= IDLE;
            end
          end else if (DUTY_LD) begin
            duty_pend_q <= duty_in_clamped;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PWM_OUT    = pwm_q;
  assign UPD_PEND   = (state_q == PENDING);
  assign UPD_DONE   = upd_done_q;
  assign PERIOD_END = period_end_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare: vector table, directed corner sequences, randomized run vs model.
module tb_pwm_compare;

`ifdef PWM_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cntr;
  logic [4:0] duty_in;
  logic       duty_ld;
  logic       pwm_out, upd_pend, upd_done, period_end;

  always #5 clk = ~clk;

  pwm_compare dut (
    .CLoK(clk), .RST_N(rst_n), .CNTR(cntr), .DUTY_IN(duty_in), .DUTY_LD(duty_ld),
    .PWM_OUT(pwm_out), .UPD_PEND(upd_pend), .UPD_DONE(upd_done), .PERIOD_END(period_end)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: the duty in force plus an optional waiting duty.
  int m_act  = 8;
  bit m_pv   = 1'b0;
  int m_pval = 0;

  int cnt = 0;

  typedef struct {
    logic [3:0] c;
    logic       ld;
    logic [4:0] din;
    logic       pwm, pend, done, pe;
  } vec_t;
  vec_t tbl[48];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int clampf(input int d);
    return (d > 16) ? 16 : d;
  endfunction

  task automatic tick(input int c, input bit ld, input int d);
    int e_pwm, e_pe, e_done;
    @(negedge clk);
    cntr = 4'(c); duty_ld = ld; duty_in = 5'(d);
    @(posedge clk);
    e_pwm  = int'((c < m_act) ^ INV);
    e_pe   = int'(c == 15);
    e_done = int'((c == 15) && m_pv);
    if (c == 15 && m_pv) begin
      m_act = m_pval;
      m_pv  = ld;
      if (ld) m_pval = clampf(d);
    end else if (ld) begin
      m_pv   = 1'b1;
      m_pval = clampf(d);
    end
    #1;
    check("model_pwm", int'(pwm_out), e_pwm);
    check("model_period_end", int'(period_end), e_pe);
    check("model_upd_done", int'(upd_done), e_done);
    check("model_upd_pend", int'(upd_pend), int'(m_pv));
    $display("tick cntr=%0d ld=%0b din=%0d -> pwm=%0b pend=%0b done=%0b pe=%0b",
             c, ld, d, pwm_out, upd_pend, upd_done, period_end);
    duty_ld = 1'b0;
  endtask

  task automatic ctick(input bit ld, input int d);
    tick(cnt, ld, d);
    cnt = (cnt + 1) % 16;
  endtask

  // Runs one full period from cnt==0; highs counts cycles in the active (non-inverted) level.
  task automatic run_period(output int highs, output int dones);
    highs = 0; dones = 0;
    for (int i = 0; i < 16; i++) begin
      ctick(1'b0, 0);
      highs += int'(pwm_out ^ INV);
      dones += int'(upd_done);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm"}, int'(pwm_out), int'(INV));
    check({tag, "_pend"}, int'(upd_pend), 0);
    check({tag, "_done"}, int'(upd_done), 0);
    check({tag, "_pe"}, int'(period_end), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs, dones, total_dones;

    // Tests 1-2: 8-high periods, then a load of 4 at CNTR=5 taking effect after the wrap.
    for (int k = 0; k < 48; k++) begin
      tbl[k].c    = 4'(k % 16);
      tbl[k].ld   = (k == 21);
      tbl[k].din  = (k == 21) ? 5'd4 : 5'd0;
      tbl[k].pwm  = ((k % 16) < ((k < 32) ? 8 : 4)) ^ INV;
      tbl[k].pend = (k >= 21 && k <= 30);
      tbl[k].done = (k == 31);
      tbl[k].pe   = ((k % 16) == 15);
    end

    rst_n = 1'b0; cntr = '0; duty_in = '0; duty_ld = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 48; k++) begin
      tick(int'(tbl[k].c), tbl[k].ld, int'(tbl[k].din));
      check($sformatf("vec%0d_pwm", k), int'(pwm_out), int'(tbl[k].pwm));
      check($sformatf("vec%0d_pend", k), int'(upd_pend), int'(tbl[k].pend));
      check($sformatf("vec%0d_done", k), int'(upd_done), int'(tbl[k].done));
      check($sformatf("vec%0d_pe", k), int'(period_end), int'(tbl[k].pe));
    end
    cnt = 0;

    // Test 3: duty 0, 16 and clamped 20.
    for (int j = 0; j < 3; j++) begin
      int req, want;
      req  = (j == 0) ? 0 : (j == 1) ? 16 : 20;
      want = (j == 0) ? 0 : 16;
      for (int i = 0; i < 16; i++) ctick(i == 7, req);
      run_period(highs, dones);
      check($sformatf("duty%0d_highs", req), highs, want);
    end

    // Test 4: last write within a period wins.
    for (int i = 0; i < 16; i++) ctick(i == 2 || i == 9, (i == 2) ? 3 : 11);
    run_period(highs, dones);
    check("last_write_wins_highs", highs, 11);

    // Test 5: load 6 on the wrap edge while 2 is pending.
    for (int i = 0; i < 15; i++) ctick(i == 3, 2);
    ctick(1'b1, 6);
    total_dones = int'(upd_done);
    run_period(highs, dones);
    check("wrap_load_first_highs", highs, 2);
    total_dones += dones;
    run_period(highs, dones);
    check("wrap_load_second_highs", highs, 6);
    total_dones += dones;
    check("wrap_load_done_pulses", total_dones, 2);

    // Test 6: reset while 12 is pending.
    for (int i = 0; i < 6; i++) ctick(i == 4, 12);
    check("pre_reset_pend", int'(upd_pend), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    check_reset_outputs("held_reset");
    @(negedge clk); rst_n = 1'b1;
    m_act = 8; m_pv = 1'b0; cnt = 0;
    run_period(highs, dones);
    check("post_reset_highs", highs, 8);
    check("post_reset_pend", int'(upd_pend), 0);

    // Randomized run with occasional counter jumps.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) cnt = int'($urandom_range(0, 15));
      ctick($urandom_range(0, 7) == 0, int'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
